// File: rtl/pwm_cfg_master.sv
// AXI4-Lite write master that programs a table of PWM channel settings
// (period, width, enable) into consecutive register blocks on a start request.
module pwm_cfg_master #(
    parameter int unsigned NUM_CHANNELS = 6,
    parameter logic [31:0] BASE_ADDR    = 32'h43C00000,
    parameter logic [31:0] CH_STRIDE    = 32'h10
) (
    input  logic        m_axi_aclk,
    input  logic        m_axi_areset,
    input  logic        start,
    input  logic        cfg_we,
    input  logic [2:0]  cfg_ch,
    input  logic        cfg_en,
    input  logic [31:0] cfg_period,
    input  logic [31:0] cfg_width,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] m_axi_awaddr,
    output logic [2:0]  m_axi_awprot,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_RESP,
        S_NEXT,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  ch_q, ch_d;
    logic [1:0]  op_q, op_d;
    logic        load;
    logic        aw_done_q, w_done_q;
    logic        err_q;
    logic [31:0] awaddr_q, wdata_q;
    logic [31:0] nxt_addr, nxt_data;
    logic        aw_hs, w_hs, b_hs, last_tx;

    logic        tbl_en     [NUM_CHANNELS];
    logic [31:0] tbl_period [NUM_CHANNELS];
    logic [31:0] tbl_width  [NUM_CHANNELS];

    assign aw_hs   = m_axi_awvalid & m_axi_awready;
    assign w_hs    = m_axi_wvalid & m_axi_wready;
    assign b_hs    = m_axi_bvalid & m_axi_bready;
    assign last_tx = (ch_q == 3'(NUM_CHANNELS - 1)) && (op_q == 2'd2);

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        op_d    = op_q;
        load    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ADDR;
                    ch_d    = 3'd0;
                    op_d    = 2'd0;
                    load    = 1'b1;
                end
            end
            S_ADDR: begin
                // AW and W may complete in either order or together
                if ((aw_done_q | aw_hs) && (w_done_q | w_hs))
                    state_d = S_RESP;
            end
            S_RESP: begin
                if (b_hs)
                    state_d = S_NEXT;
            end
            S_NEXT: begin
                if (last_tx) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_ADDR;
                    load    = 1'b1;
                    if (op_q == 2'd2) begin
                        ch_d = ch_q + 3'd1;
                        op_d = 2'd0;
                    end else begin
                        op_d = op_q + 2'd1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Per channel: period at +4, width at +8, then the enable at +0
    always_comb begin
        nxt_addr = BASE_ADDR + 32'(ch_d) * CH_STRIDE;
        nxt_data = {31'd0, tbl_en[ch_d]};
        case (op_d)
            2'd0: begin
                nxt_addr = nxt_addr + 32'd4;
                nxt_data = tbl_period[ch_d];
            end
            2'd1: begin
                nxt_addr = nxt_addr + 32'd8;
                nxt_data = tbl_width[ch_d];
            end
            default: ;
        endcase
    end

    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            state_q   <= S_IDLE;
            ch_q      <= 3'd0;
            op_q      <= 2'd0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            err_q     <= 1'b0;
            awaddr_q  <= 32'd0;
            wdata_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            op_q    <= op_d;
            if (load) begin
                awaddr_q <= nxt_addr;
                wdata_q  <= nxt_data;
            end
            if (state_d != S_ADDR)
                aw_done_q <= 1'b0;
            else if (aw_hs)
                aw_done_q <= 1'b1;
            if (state_d != S_ADDR)
                w_done_q <= 1'b0;
            else if (w_hs)
                w_done_q <= 1'b1;
            if ((state_q == S_IDLE) && start)
                err_q <= 1'b0;
            else if (b_hs && (m_axi_bresp != 2'b00))
                err_q <= 1'b1;
        end
    end

    // Table is frozen while a sequence is running so every write sees one snapshot
    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
                tbl_en[i]     <= 1'b0;
                tbl_period[i] <= 32'd0;
                tbl_width[i]  <= 32'd0;
            end
        end else if (cfg_we && !busy && ({29'd0, cfg_ch} < NUM_CHANNELS)) begin
            tbl_en[cfg_ch]     <= cfg_en;
            tbl_period[cfg_ch] <= cfg_period;
            tbl_width[cfg_ch]  <= cfg_width;
        end
    end

    assign busy          = (state_q == S_ADDR) || (state_q == S_RESP) || (state_q == S_NEXT);
    assign done          = (state_q == S_DONE);
    assign err           = err_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_awvalid = (state_q == S_ADDR) && !aw_done_q;
    assign m_axi_wvalid  = (state_q == S_ADDR) && !w_done_q;
    assign m_axi_bready  = (state_q == S_RESP);

endmodule

// File: doc/pwm_cfg_master.md
PWM_CFG_MASTER -- requirements
Module: pwm_cfg_master

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- NUM_CHANNELS, 6, PWM channels programmed (1..8).
- BASE_ADDR, 32'h43C00000, AXI address of channel 0.
- CH_STRIDE, 32'h10, address step between channels.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- m_axi_aclk, in, 1, sole clock, rising edge.
- m_axi_areset, in, 1, reset, synchronous, active-high.
- start, in, 1, one-cycle request to program all channels.
- cfg_we, in, 1, config table write strobe.
- cfg_ch, in, 3, table entry index.
- cfg_en, in, 1, enable value for entry.
- cfg_period, in, 32, period value for entry.
- cfg_width, in, 32, pulse-width value for entry.
- busy, out, 1, sequence in progress.
- done, out, 1, one-cycle pulse at sequence end.
- err, out, 1, sticky: some write got non-OKAY BRESP.
- m_axi_awaddr, out, 32, write address.
- m_axi_awprot, out, 3, constant 3'b000.
- m_axi_awvalid, out, 1, address valid.
- m_axi_awready, in, 1, address accepted.
- m_axi_wdata, out, 32, write data.
- m_axi_wstrb, out, 4, constant 4'hF.
- m_axi_wvalid, out, 1, data valid.
- m_axi_wready, in, 1, data accepted.
- m_axi_bresp, in, 2, write response.
- m_axi_bvalid, in, 1, response valid.
- m_axi_bready, out, 1, response accept.

Function
REQ-003 Table: NUM_CHANNELS entries of {en, period[31:0], width[31:0]}. cfg_we writes entry cfg_ch at the clock edge. The write is ignored if cfg_ch >= NUM_CHANNELS or busy=1.

REQ-004 Sequence: channels 0..NUM_CHANNELS-1 in order. Per channel, 3 writes in this order:
- period to BASE_ADDR+ch*CH_STRIDE+4
- width to +8
- {31'b0,en} to +0
Total: 3*NUM_CHANNELS transactions.

REQ-005 Values SHALL be written unchanged. width>period and width=0 are legal and are not checked.

REQ-006 FSM states and transitions:
- IDLE: start=1 goes to ADDR.
- ADDR: when both AW and W have handshaken, go to RESP.
- RESP: on bvalid&bready, go to NEXT.
- NEXT: go to ADDR for the next transaction, or to DONE after the last.
- DONE: go to IDLE.

REQ-007 start sampled in IDLE SHALL assert busy, awvalid and wvalid on the following cycle. start while busy=1 is ignored.

REQ-008 AW/W handshake:
- awvalid and wvalid rise in the same cycle.
- Each drops on the cycle after its own ready is sampled high with valid=1. The two channels complete independently.
- awaddr and wdata stay stable while the corresponding valid is high.

REQ-009 bready=1 only in RESP. A B handshake with bresp!=2'b00 sets err. The sequence continues; no retry.

REQ-010 err SHALL clear when a new start is accepted.

REQ-011 Timing with ready=1 and bvalid one cycle after the AW/W handshake: each transaction takes 4 cycles (ADDR, RESP, RESP, NEXT).

REQ-012 done SHALL pulse for exactly 1 cycle, during DONE. busy falls in the same cycle done is high. The block returns to IDLE the next cycle.

REQ-013 Address arithmetic is 32-bit modulo. Overflow wraps silently.

REQ-014 bvalid outside RESP SHALL be ignored and is not counted.

Reset
REQ-015 An edge with m_axi_areset=1 SHALL, from the next cycle:
- put the FSM in IDLE;
- clear the table;
- drive busy, done, err, awvalid, wvalid, bready low;
- drive awaddr and wdata to 0.
This applies even mid-transaction. The outstanding AXI write is abandoned, and a reset never produces a done pulse.

Verification
REQ-016 Program entries ch k: en=1, period=15, width=2k (NUM_CHANNELS=6). Pulse start with a zero-wait slave. Required: 18 writes, exactly 0x43C00004=15, 0x43C00008=0, 0x43C00000=1, ..., 0x43C00054=15, 0x43C00058=10, 0x43C00050=1, in that order. done pulses once; busy is high for 72 cycles; err=0.

REQ-017 Slave raises awready 3 cycles after wready. Required: wvalid drops first, awvalid holds with a stable address, and the B phase starts only after both handshakes.

REQ-018 Slave returns bresp=2'b10 on the 5th write. Required: err=1 from then on, all 18 writes still issued, done pulses. err clears on the next start.

REQ-019 Second start while busy, and cfg_we ch0 width=7 while busy. Required: both ignored; the next sequence writes the original width.

REQ-020 Assert reset during write 4's ADDR phase. Required: next cycle awvalid=wvalid=busy=0, no done pulse. A following start, with an empty table, writes zeros to all 18 addresses.
